// File: rtl/ba4_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ba4_pkg: shared nibble width and FSM state encoding for the       |
// | nibble-serial adder.                 Rev 1.0 - initial release    |
// +------------------------------------------------------------------+
package ba4_pkg;
  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ba4_state_t;
endpackage
`default_nettype wire

// File: rtl/ba4_serial_adder_ba_4bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | BA_4bit: 4-bit unsigned binary adder, {cout,sum} = a + b.         |
// |                                      Rev 1.0 - initial release    |
// +------------------------------------------------------------------+
module BA_4bit (
  output logic [3:0] sum,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule
`default_nettype wire

// File: rtl/ba4_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ba4_serial_adder: adds two NIBBLES*4-bit operands one nibble per  |
// | clock through BA_4bit, rippling carry in a register.              |
// |                                      Rev 1.0 - initial release    |
// +------------------------------------------------------------------+
module ba4_serial_adder
  import ba4_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] a_in,
  input  logic [NIB_W*NIBBLES-1:0] b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] sum_out,
  output logic                     cout_out
);
  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NIBBLES - 1);

  ba4_state_t       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [NIB_W-1:0] nib_a, nib_b, s1, s2;
  logic             c1, c2;

  BA_4bit u_add (.sum(s1), .cout(c1), .a(nib_a), .b(nib_b));
  BA_4bit u_cin (.sum(s2), .cout(c2), .a(s1),    .b({3'b000, carry_q}));

  always_comb begin
    nib_a       = '0;
    nib_b       = '0;
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    // Constant-index mux keeps the nibble select width-clean for any NIBBLES.
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIB_W +: NIB_W];
        nib_b = b_q[i*NIB_W +: NIB_W];
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a_in;
          b_d        = b_in;
          carry_d    = 1'b0;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*NIB_W +: NIB_W] = s2;
        end
        carry_d = c1 | c2;
        if (idx_q == C_IDX_LAST) begin
          cout_d      = c1 | c2;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;
endmodule
`default_nettype wire

// File: tb/tb_ba4_serial_adder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ba4_serial_adder: self-checking bench, NIBBLES=4 and NIBBLES=1 |
// | instances against an arithmetic a+b reference.  Rev 1.0           |
// +------------------------------------------------------------------+
module tb_ba4_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        in_valid, in_ready, out_valid, out_ready, cout_out;
  logic [15:0] a_in, b_in, sum_out;
  // NIBBLES=1 instance
  logic        n1_in_valid, n1_in_ready, n1_out_valid, n1_out_ready, n1_cout_out;
  logic [3:0]  n1_a_in, n1_b_in, n1_sum_out;

  int total = 0;
  int bad   = 0;

  ba4_serial_adder #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out)
  );

  ba4_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .a_in(n1_a_in), .b_in(n1_b_in), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .sum_out(n1_sum_out), .cout_out(n1_cout_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one pair, wait for the result, check latency and value, then drain.
  task automatic op4(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [16:0] exp;
    logic [15:0] s_hold;
    logic        c_hold;
    int lat;
    exp = {1'b0, a} + {1'b0, b};
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL op4_in_ready got=%b want=1", in_ready);
    end
    in_valid = 1'b1; a_in = a; b_in = b;
    tick();
    in_valid = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
    lat = 0;
    do begin tick(); lat++; end while (!out_valid && lat < 20);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL op4_latency got=%0d want=4", lat);
    end
    total++;
    if ({cout_out, sum_out} !== exp) begin
      bad++; $display("FAIL op4_sum a=%h b=%h got=%b/%h want=%b/%h",
                      a, b, cout_out, sum_out, exp[16], exp[15:0]);
    end
    s_hold = sum_out; c_hold = cout_out;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; a_in = 16'hAAAA; b_in = 16'h5555;
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_out !== s_hold || cout_out !== c_hold) begin
        bad++; $display("FAIL hold_stable got=v%b r%b %b/%h want=v1 r0 %b/%h",
                        out_valid, in_ready, cout_out, sum_out, c_hold, s_hold);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum_out !== s_hold) begin
      bad++; $display("FAIL op4_drain got=v%b r%b %h want=v0 r1 %h",
                      out_valid, in_ready, sum_out, s_hold);
    end
    // A pulse ignored while busy must not start a new operation.
    tick();
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL op4_idle_after got=%b want=1", in_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum_out !== 16'h0 || cout_out !== 1'b0) begin
      bad++; $display("FAIL reset_state got=r%b v%b %b/%h want=r1 v0 0/0000",
                      in_ready, out_valid, cout_out, sum_out);
    end
    total++;
    if (n1_in_ready !== 1'b1 || n1_out_valid !== 1'b0 || n1_sum_out !== 4'h0 || n1_cout_out !== 1'b0) begin
      bad++; $display("FAIL reset_state_n1 got=r%b v%b %b/%h want=r1 v0 0/0",
                      n1_in_ready, n1_out_valid, n1_cout_out, n1_sum_out);
    end
  endtask

  task automatic test_directed();
    op4(16'h0006, 16'h000A, 0);
    op4(16'hFFFF, 16'h0001, 0);
    op4(16'h1234, 16'h4321, 3);
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || sum_out !== 16'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=v%b %h r%b want=v0 0000 r1", out_valid, sum_out, in_ready);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL mid_reset_no_result got=%b want=0", out_valid);
      end
    end
    op4(16'h0001, 16'h0001, 0);
  endtask

  task automatic test_one_nibble();
    logic [3:0] av [4] = '{4'hC, 4'h2, 4'h1, 4'h9};
    logic [3:0] bv [4] = '{4'hB, 4'h1, 4'hC, 4'h4};
    for (int i = 0; i < 4; i++) begin
      logic [4:0] exp;
      int lat;
      exp = {1'b0, av[i]} + {1'b0, bv[i]};
      n1_in_valid = 1'b1; n1_a_in = av[i]; n1_b_in = bv[i];
      tick();
      n1_in_valid = 1'b0;
      lat = 0;
      do begin tick(); lat++; end while (!n1_out_valid && lat < 20);
      total++;
      if (lat !== 1 || {n1_cout_out, n1_sum_out} !== exp) begin
        bad++; $display("FAIL n1_op%0d got=lat%0d %b want=lat1 %b", i, lat,
                        {n1_cout_out, n1_sum_out}, exp);
      end
      n1_out_ready = 1'b1;
      tick();
      n1_out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    logic [15:0] a, b;
    int cyc, seen;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      a = (n == 0) ? 16'hFFFF : 16'($urandom);
      b = (n == 0) ? 16'hFFFF : 16'($urandom);
      exp = {1'b0, a} + {1'b0, b};
      in_valid = 1'b1; a_in = a; b_in = b;
      tick();
      a_in = 16'($urandom); b_in = 16'($urandom);
      cyc = 0; seen = 0;
      do begin
        tick(); cyc++;
        if (out_valid) begin
          seen++;
          total++;
          if (cyc !== 4 || {cout_out, sum_out} !== exp) begin
            bad++; $display("FAIL b2b_result n=%0d got=cyc%0d %b/%h want=cyc4 %b/%h",
                            n, cyc, cout_out, sum_out, exp[16], exp[15:0]);
          end
        end
      end while (!in_ready && cyc < 20);
      total++;
      if (cyc !== 5 || seen !== 1) begin
        bad++; $display("FAIL b2b_ready n=%0d got=cyc%0d seen%0d want=cyc5 seen1", n, cyc, seen);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_a_in = '0; n1_b_in = '0;
    tick(); tick();
    rst = 1'b0;
    test_reset();
    test_directed();
    test_mid_reset();
    test_one_nibble();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
